// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants and the adder arbiter state encoding
package fpu_pkg;

  localparam int FP_WIDTH = 32;

  // IEEE-754 single-precision patterns used when exercising the adder path
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_QNAN    = 32'hFFC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/fpu_rr_pick.sv
// rtl/fpu_rr_pick.sv - combinational round-robin picker starting at ptr with wrap
module fpu_rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      gnt_idx,
  output logic               any
);

  logic [NUM_REQ-1:0] rot;
  logic [IW:0]        off;
  logic [IW:0]        sum;

  // rotate requests so ptr lands at bit 0, take the lowest set bit, then undo the rotation
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    any = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        off = (IW+1)'(j);
        any = 1'b1;
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IW+1)'(NUM_REQ)) begin
      sum = sum - (IW+1)'(NUM_REQ);
    end
    gnt_idx = sum[IW-1:0];
  end

endmodule

// File: rtl/fpu_add_arbiter.sv
// rtl/fpu_add_arbiter.sv - round-robin sharing of one single-precision adder among requesters
module fpu_add_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = FP_WIDTH,
  parameter int TIMEOUT = 255,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_z,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic                     add_start,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_ack,
  input  logic [WIDTH-1:0]         add_z,
  input  logic                     add_valid,
  input  logic                     add_idle,
  output logic [IW-1:0]            grant_id,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  arb_state_e       state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res_z;
  logic [CW-1:0]    to_cnt;

  fpu_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // a grant also needs the adder back in its idle state, which covers its reset recovery
  assign grant     = (state == ST_IDLE) && add_idle && pick_any;
  assign add_start = (state == ST_ISSUE);
  assign add_ack   = (state == ST_WAIT);
  assign busy      = (state != ST_IDLE);
  // operands stay latched until the next grant because the adder captures them late
  assign add_a     = op_a;
  assign add_b     = op_b;
  assign resp_z    = res_z;

  // sequencing: grant -> start pulse -> wait for sum -> hold response until the owner takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      res_z      <= '0;
      req_ready  <= '0;
      resp_valid <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            op_a      <= req_a[pick_idx*WIDTH +: WIDTH];
            op_b      <= req_b[pick_idx*WIDTH +: WIDTH];
            grant_id  <= pick_idx;
            req_ready <= NUM_REQ'(1) << pick_idx;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (add_valid) begin
            res_z      <= add_z;
            resp_valid <= NUM_REQ'(1) << grant_id;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready[grant_id]) begin
            resp_valid <= '0;
            rr_ptr     <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // saturating WAIT-cycle counter; the error flag is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (state == ST_ISSUE) begin
      to_cnt <= '0;
    end else if ((state == ST_WAIT) && (to_cnt != TO_MAX)) begin
      to_cnt <= to_cnt + 1'b1;
      if (to_cnt == TO_LAST) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// tb/tb_fpu_add_arbiter.sv - scoreboard bench for the adder arbiter with a behavioural adder stub
module tb_fpu_add_arbiter;
  import fpu_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam int NOPS = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   resp_z, add_a, add_b, add_z;
  logic           add_start, add_ack, add_valid, add_idle, busy, err_timeout;
  logic [1:0]     grant_id;

  fpu_add_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_z(resp_z), .resp_ready(resp_ready),
    .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_ack(add_ack), .add_z(add_z),
    .add_valid(add_valid), .add_idle(add_idle), .grant_id(grant_id), .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // operand table: 1+2, 2+2, 5+1, 4+4, 1+1, +inf + -inf
  logic [31:0] tab_a [NOPS] = '{32'h3F80_0000, 32'h4000_0000, 32'h40A0_0000, 32'h4080_0000, 32'h3F80_0000, FP_POS_INF};
  logic [31:0] tab_b [NOPS] = '{32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4080_0000, 32'h3F80_0000, 32'hFF80_0000};
  logic [31:0] tab_z [NOPS] = '{32'h4040_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000, 32'h4000_0000, FP_QNAN};

  typedef struct { int idx; logic [31:0] z; } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  logic [N-1:0] again;
  int rearm_op [N];
  int hold_idx;
  int lat_last, starts_seen, accepts_seen;
  bit never_valid;

  // adder stub
  function automatic logic [31:0] stub_sum(input logic [31:0] a, input logic [31:0] b);
    stub_sum = 32'hDEAD_BEEF;
    for (int k = 0; k < NOPS; k++) if (tab_a[k] == a && tab_b[k] == b) stub_sum = tab_z[k];
  endfunction

  function automatic int stub_lat(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 2;
    return 6;
  endfunction

  int sst, scnt;
  logic [31:0] sz;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sst <= 0; scnt <= 3; add_valid <= 1'b0; add_idle <= 1'b0; add_z <= '0; sz <= '0;
    end else begin
      case (sst)
        0: if (scnt == 0) begin add_idle <= 1'b1; sst <= 1; end else scnt <= scnt - 1;
        1: if (add_start) begin add_idle <= 1'b0; sst <= 2; end
        2: begin sz <= stub_sum(add_a, add_b); scnt <= stub_lat(add_a, add_b) - 1; sst <= 3; end
        3: if (!never_valid) begin
             if (scnt == 0) begin add_valid <= 1'b1; add_z <= sz; sst <= 4; end
             else scnt <= scnt - 1;
           end
        4: if (add_ack) begin add_valid <= 1'b0; sst <= 5; end
        default: begin add_idle <= 1'b1; sst <= 1; end
      endcase
    end
  end

  task automatic issue(input int i, input int op);
    req_a[i*W +: W] = tab_a[op];
    req_b[i*W +: W] = tab_b[op];
    req_valid[i] = 1'b1;
    sb.push_back('{idx: i, z: tab_z[op]});
  endtask

  // services acceptances and responses until n results have been checked against the scoreboard
  task automatic collect(input int n, input int budget);
    int got = 0, cyc = 0, start_cyc = 0;
    bit bad;
    exp_t e;
    logic [N-1:0] hv;
    logic [31:0] hz;
    while (got < n && cyc < budget) begin
      @(negedge clk); cyc++;
      resp_ready = '0;
      if (add_start) begin starts_seen++; start_cyc = cyc; end
      if (req_ready != '0) begin
        accepts_seen++;
        checks++;
        if (!$onehot(req_ready)) begin errors++; $display("FAIL req_ready_onehot got=%b", req_ready); end
        for (int i = 0; i < N; i++) if (req_ready[i]) req_valid[i] = 1'b0;
      end
      if (resp_valid != '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL unexpected_resp resp_valid=%b expected=none", resp_valid);
          resp_ready = resp_valid;
        end else begin
          e = sb.pop_front();
          if (resp_valid !== (N'(1) << e.idx)) begin errors++; $display("FAIL resp_valid got=%b expected=%b", resp_valid, N'(1) << e.idx); end
          checks++;
          if (resp_z !== e.z) begin errors++; $display("FAIL resp_z req=%0d got=%h expected=%h", e.idx, resp_z, e.z); end
          lat_last = cyc - start_cyc;
          if (e.idx == hold_idx) begin
            hv = resp_valid; hz = resp_z; bad = 0;
            resp_ready = ~(N'(1) << e.idx);
            for (int h = 0; h < 10; h++) begin
              @(negedge clk); cyc++;
              if (resp_valid !== hv || resp_z !== hz || add_start !== 1'b0 || req_ready !== '0) bad = 1;
            end
            checks++;
            if (bad) begin errors++; $display("FAIL resp_hold_stable got=%b/%h expected=%b/%h", resp_valid, resp_z, hv, hz); end
            hold_idx = -1;
          end
          resp_ready = N'(1) << e.idx;
          if (again[e.idx]) begin again[e.idx] = 1'b0; issue(e.idx, rearm_op[e.idx]); end
        end
        got++;
      end
    end
    @(negedge clk);
    resp_ready = '0;
    checks++;
    if (got != n) begin errors++; $display("FAIL collect_timeout got=%0d expected=%0d", got, n); end
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i]) req_valid[i] = 1'b0;
      if (add_ack) begin ok = 1; break; end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = '0; resp_ready = '0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, add_start, add_ack, busy, err_timeout, grant_id} !== '0) begin
      errors++; $display("FAIL reset_ctrl got=%b expected=0", {req_ready, resp_valid, add_start, add_ack, busy, err_timeout, grant_id});
    end
    checks++;
    if ({resp_z, add_a, add_b} !== '0) begin errors++; $display("FAIL reset_data got=%h expected=0", {resp_z, add_a, add_b}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    starts_seen = 0; accepts_seen = 0;
    issue(0, 0);
    collect(1, 60);
    checks++;
    if (starts_seen != 1) begin errors++; $display("FAIL single_start_pulses got=%0d expected=1", starts_seen); end
    checks++;
    if (accepts_seen != 1) begin errors++; $display("FAIL single_accepts got=%0d expected=1", accepts_seen); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < N; i++) issue(i, i);
    again = 4'b0001; rearm_op[0] = 4;
    starts_seen = 0;
    collect(5, 300);
    checks++;
    if (starts_seen != 5) begin errors++; $display("FAIL rr_start_pulses got=%0d expected=5", starts_seen); end
  endtask

  task automatic test_resp_stall();
    hold_idx = 2;
    issue(2, 1);
    issue(3, 3);
    collect(2, 200);
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL no_timeout_normal got=%b expected=0", err_timeout); end
  endtask

  task automatic test_special();
    int lat_norm;
    issue(3, 4);
    collect(1, 60);
    lat_norm = lat_last;
    issue(3, 5);
    collect(1, 60);
    checks++;
    if (lat_last >= lat_norm) begin errors++; $display("FAIL special_latency got=%0d expected<%0d", lat_last, lat_norm); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok, granted, bad, idle_prev;
    int cyc;
    issue(1, 0);
    wait_ack(30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midwait_reach_wait got=0 expected=1"); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, add_start, add_ack, busy, err_timeout, grant_id} !== '0) begin
      errors++; $display("FAIL midwait_reset_ctrl got=%b expected=0", {req_ready, resp_valid, add_start, add_ack, busy, err_timeout, grant_id});
    end
    checks++;
    if ({resp_z, add_a, add_b} !== '0) begin errors++; $display("FAIL midwait_reset_data got=%h expected=0", {resp_z, add_a, add_b}); end
    sb.delete();
    req_valid = '0;
    issue(1, 2);
    @(negedge clk);
    rst_n = 1'b1;
    idle_prev = add_idle; granted = 0; bad = 0; cyc = 0;
    while (!granted && cyc < 20) begin
      @(negedge clk); cyc++;
      if (req_ready != '0) begin
        granted = 1;
        if (!idle_prev || req_ready !== 4'b0010 || grant_id !== 2'd1) bad = 1;
        req_valid[1] = 1'b0;
      end
      idle_prev = add_idle;
    end
    checks++;
    if (!granted || bad || cyc < 2) begin
      errors++; $display("FAIL midwait_regrant granted=%0d bad=%0d cycles=%0d expected granted after add_idle", granted, bad, cyc);
    end
    collect(1, 60);
  endtask

  task automatic test_timeout();
    bit ok, bad;
    int n;
    never_valid = 1'b1;
    issue(2, 0);
    wait_ack(30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_reach_wait got=0 expected=1"); end
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (err_timeout) break;
      if (add_ack) n++;
      @(negedge clk);
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL timeout_wait_cycles got=%0d expected=16", n); end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (err_timeout !== 1'b1 || busy !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL timeout_sticky got err=%b busy=%b expected=1/1", err_timeout, busy); end
    never_valid = 1'b0;
    apply_reset();
    #1;
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_cleared_by_reset got=%b expected=0", err_timeout); end
  endtask

  initial begin
    req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0;
    again = '0; hold_idx = -1; never_valid = 1'b0;
    for (int i = 0; i < N; i++) rearm_op[i] = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_resp_stall();
    test_special();
    test_reset_mid_wait();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_add_arbiter.md
# fpu_add_arbiter

Round-robin arbiter and sequencer that shares one single-precision `adder` instance among `NUM_REQ` requesters. It drives the adder's `start`/`ack_output` handshake and holds operands stable for the whole operation. It returns each sum to the requester that issued it. It sits between the requester ports of the FPU front-end and the adder core.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: operand/result width. Fixed at 32 for the adder.
- `TIMEOUT`, 255: number of cycles in WAIT before `err_timeout` is set.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low, single clock domain.
- `req_valid`  in  NUM_REQ  per-requester operation request.
- `req_a`, `req_b`  in  NUM_REQ*WIDTH  packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NUM_REQ  one-hot acceptance pulse.
- `resp_valid`  out  NUM_REQ  one-hot result valid.
- `resp_z`  out  WIDTH  shared result bus; meaningful only while `resp_valid` is nonzero.
- `resp_ready`  in  NUM_REQ  per-requester result accept.
- `add_start`  out  1  drives adder `start`.
- `add_a`, `add_b`  out  WIDTH  drive adder `input_a`/`input_b`.
- `add_ack`  out  1  drives adder `ack_output`.
- `add_z`  in  WIDTH  from adder `output_z`.
- `add_valid`  in  1  from adder `output_valid`.
- `add_idle`  in  1  from adder `idle_status`.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current owner.
- `busy`  out  1  high whenever the state is not IDLE.
- `err_timeout`  out  1  sticky; cleared only by reset.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant condition: `add_idle`=1 and |`req_valid`.
  - Winner: the first index with `req_valid` set, searching from `rr_ptr` upward with wrap.
  - On grant: latch `req_a`/`req_b` of the winner into `op_a`/`op_b`, set `grant_id`, pulse `req_ready[winner]` for 1 cycle, go to ISSUE.
- ISSUE: `add_start`=1 for exactly 1 cycle, then go to WAIT.
- WAIT:
  - `add_ack`=1 for the whole state. This lets the adder pass its result state in one cycle and retire its valid state.
  - When `add_valid`=1: capture `add_z` into `res_z` and go to RESP.
  - Timeout counter: increments every WAIT cycle. On reaching `TIMEOUT` it sets `err_timeout` and the FSM stays in WAIT. The counter saturates and clears on entry to WAIT.
- RESP:
  - `resp_valid[grant_id]`=1 and `resp_z`=`res_z`, both held stable.
  - When `resp_ready[grant_id]`=1: `rr_ptr` <= (`grant_id`+1) mod `NUM_REQ`, go to IDLE.
- `add_a`/`add_b` = `op_a`/`op_b` at all times. They are stable from ISSUE until the next grant, covering the adder's delayed operand capture.
- `resp_ready` of non-owners is ignored. A requester keeps its own `req_valid`; requests are never dropped.
- Reset (any state, including mid-WAIT):
  - State = IDLE, `rr_ptr`=0.
  - All outputs 0: `req_ready`, `resp_valid`, `resp_z`, `add_start`, `add_a`, `add_b`, `add_ack`, `grant_id`, `busy`, `err_timeout`.
  - The adder's own reset is driven from the same system reset. The arbiter issues nothing until `add_idle` returns to 1.

## Timing
- Request accepted at edge T0. `add_start` is high in cycle T0+1.
- Adder latency is data-dependent: align and normalise loops, special-case shortcut. The arbiter imposes no fixed latency.
- Arbiter overhead:
  - 1 cycle from accept to start.
  - 1 cycle from `add_valid` to `resp_valid`.
  - At least 1 cycle in IDLE between operations, waiting on `add_idle`.
- `req_ready` and `resp_valid` are registered outputs; `add_start` and `add_ack` are decoded from registered state.
- Simultaneous requests resolve by round-robin order only. A new request arriving in the same cycle as a `resp_ready` handshake is considered in the following IDLE cycle.

## Structure
- Shared package `fpu_pkg` holds:
  - the arbiter state enum (IDLE/ISSUE/WAIT/RESP);
  - `FP_WIDTH`=32;
  - the constants `FP_POS_INF`=0x7F800000 and `FP_QNAN`=0xFFC00000 used by benches.
- Sub-module `fpu_rr_pick`: combinational round-robin picker. Inputs `req` and `ptr`; outputs `gnt_idx` and `any`.

## Test plan
- Requester 0 sends a=0x3F800000, b=0x40000000 -> `req_ready[0]` pulses once; `resp_valid[0]` goes high with `resp_z`=0x40400000; `add_start` is high for exactly 1 cycle.
- All 4 `req_valid` high from reset with distinct operands -> grant order is 0,1,2,3, then wraps to 0; each result lands only on its own `resp_valid` bit.
- `resp_ready[2]` held low for 10 cycles -> `resp_valid[2]` and `resp_z` stay stable, `add_start` stays low, and no other `req_ready` fires.
- a=0x7F800000, b=0xFF800000 -> `resp_z`=0xFFC00000; response arrives earlier than a normal-operand add.
- `rst_n` asserted low mid-WAIT -> all outputs read 0 immediately; after release, the first grant waits for `add_idle`=1.
- Stub adder that never asserts `add_valid`, `TIMEOUT`=16 -> `err_timeout` rises after 16 WAIT cycles and stays high; `busy` stays 1.
